// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder: a single 4-bit slice is reused once per clock, LSB nibble first,
// with the inter-nibble carry held in a register.

module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 8
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 ci,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] s,
    output logic                 co,
    output logic                 ov,
    output logic [1:0]           fsm_state
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            a_msb;
    logic            b_msb;
    logic [3:0]      sum4;
    logic            c4;

    // The slice sees only registered operands, so its timing is independent of a/b/ci.
    add4 u_add4 (
        .a  (a_sh[3:0]),
        .b  (b_sh[3:0]),
        .ci (carry),
        .s  (sum4),
        .co (c4)
    );

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= ci;
                        a_msb <= a[W-1];
                        b_msb <= b[W-1];
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        done <= 1'b0;
                        if (state == DONE) state <= IDLE;
                    end
                end
                RUN: begin
                    // Sum nibbles enter from the top so nibble 0 lands in s[3:0] at the end.
                    s     <= {sum4, s[W-1:4]};
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    carry <= c4;
                    if (cnt == LAST) begin
                        co    <= c4;
                        ov    <= (a_msb == b_msb) && (sum4[3] != a_msb);
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (NIBBLES=8): vector table, directed multi-cycle
// sequences and random operands against an arithmetic reference model.

module tb_nibble_serial_adder;
    localparam int N = 8;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         clrn;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic [1:0]   fsm_state;

    int n_pass  = 0;
    int n_total = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .busy      (busy),
        .done      (done),
        .s         (s),
        .co        (co),
        .ov        (ov),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: plain W-bit unsigned addition plus the signed overflow rule.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mci,
                         output logic [W-1:0] ms, output logic mco, output logic mov);
        logic [W:0] full;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mci};
        ms   = full[W-1:0];
        mco  = full[W];
        mov  = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
    endtask

    // Wait (bounded) for done after an accept edge; returns edges counted and busy cycles.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tci, input logic [W-1:0] es, input logic eco,
                          input logic eov);
        int lat, bc;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; ci = tci;
        @(posedge clk);
        #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        wait_done(lat, bc);
        check({nm, " latency"}, lat, N);
        check({nm, " busy_cycles"}, bc, N);
        check({nm, " s"}, s, es);
        check({nm, " co"}, co, eco);
        check({nm, " ov"}, ov, eov);
        @(posedge clk);
        #1;
        check({nm, " done_one_cycle"}, done, 0);
        check({nm, " back_to_idle"}, fsm_state, 0);
        check({nm, " s_held"}, s, es);
    endtask

    initial begin
        logic [W-1:0] rs, ra, rb;
        logic rco, rov, rci;
        int lat, bc, dcount;

        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0});
        vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1});
        vecs.push_back('{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0});

        // Reset block
        clrn = 1'b0; start = 1'b0; a = '1; b = '1; ci = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset s", s, 0);
        check("reset co", co, 0);
        check("reset ov", ov, 0);
        check("reset state", fsm_state, 0);
        @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
                   vecs[i].s, vecs[i].co, vecs[i].ov);

        // Start during RUN with changing operands must be ignored.
        @(negedge clk);
        start = 1'b1; a = 32'h12345678; b = 32'h9ABCDEF0; ci = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcount = 0; lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 3);
            a = (c == 3) ? '0 : W'($urandom);
            b = (c == 3) ? '0 : W'($urandom);
            ci = 1'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                dcount++;
                if (lat == 0) lat = c;
            end
            if (c == 8) check("ignore_start s", s, 32'hACF13569);
        end
        start = 1'b0;
        check("ignore_start done_pulses", dcount, 1);
        check("ignore_start latency", lat, N);

        // Reset mid-RUN discards the operation.
        @(negedge clk);
        start = 1'b1; a = 32'h12345678; b = 32'h9ABCDEF0; ci = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clrn = 1'b0;
        @(posedge clk);
        #1;
        clrn = 1'b1;
        check("midrun_reset busy", busy, 0);
        check("midrun_reset done", done, 0);
        check("midrun_reset s", s, 0);
        check("midrun_reset co", co, 0);
        check("midrun_reset ov", ov, 0);
        check("midrun_reset state", fsm_state, 0);
        run_op("after_reset", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);

        // Back-to-back: start held high, second operands presented in the DONE cycle.
        @(negedge clk);
        start = 1'b1; a = 32'hFFFFFFFF; b = 32'h00000001; ci = 1'b0;
        @(posedge clk);
        #1;
        wait_done(lat, bc);
        check("b2b first latency", lat, N);
        check("b2b first s", s, 32'h00000000);
        check("b2b first co", co, 1);
        a = 32'h12345678; b = 32'h9ABCDEF0; ci = 1'b1;
        wait_done(lat, bc);
        check("b2b period", lat, N + 1);
        check("b2b second s", s, 32'hACF13569);
        check("b2b second co", co, 0);
        check("b2b second ov", ov, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);

        // Random operands against the model.
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rci = 1'($urandom_range(0, 1));
            if (i % 5 == 0) rb = ~ra;
            model(ra, rb, rci, rs, rco, rov);
            run_op($sformatf("rand%0d", i), ra, rb, rci, rs, rco, rov);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
